sync_ram: RTL and testbench

Single-clock, parametrised simple dual-port RAM: one write port and one registered read port, each with its own address. Generalises the existing 8-bit/64K store with configurable width and depth, a read-valid flag, selectable read-during-write behaviour, and a hardware clear sweep run after reset or on request. It serves as the main memory and scratch store for the CPU datapath. Clients must hold requests until `Ready` is high.

---
 rtl/sync_ram.sv | 125 ++++++++++++
 tb/tb_sync_ram.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram.sv
// -----------------------------------------------------------------------------
// sync_ram
// Single-clock simple dual-port RAM. It has one write port and one registered
// read port, and each port has its own address. A hardware zero-fill sweep
// clears the whole array. The sweep runs after reset when CLEAR_ON_RESET=1,
// and it also runs when ClearStart is sampled high in RUN. Requests are
// accepted only while Ready is high.
//
// Parameters
//   DATA_WIDTH     word width in bits
//   ADDR_WIDTH     address width, depth = 2**ADDR_WIDTH
//   WRITE_FIRST    same-address read+write: 1 returns new data, 0 old data
//   CLEAR_ON_RESET 1: zero-fill sweep starts automatically after reset
//
// Ports
//   Clock        rising-edge clock
//   ResetN       asynchronous active-low reset (memory contents untouched)
//   WriteEnable  write request, AddrIn / DataIn
//   ReadEnable   read request, AddrOut
//   DataOut      registered read data, holds when no read is accepted
//   DataValid    DataOut was loaded by the most recent edge
//   ClearStart   request a zero-fill sweep (level-sampled in RUN)
//   Ready        high while requests are accepted
// -----------------------------------------------------------------------------
module sync_ram #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter bit          WRITE_FIRST    = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] AddrIn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  ReadEnable,
  input  logic [ADDR_WIDTH-1:0] AddrOut,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  input  logic                  ClearStart,
  output logic                  Ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  ready_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  same_addr;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Requests count only in RUN. During a sweep they are dropped entirely.
  assign rd_acc    = (state == RUN) && ReadEnable;
  assign wr_acc    = (state == RUN) && WriteEnable;
  assign same_addr = (AddrIn == AddrOut);

  // ---- control: sweep FSM and registered Ready ----
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= RUN;
      clear_addr <= '0;
      ready_p1   <= !CLEAR_ON_RESET;
    end else begin
      case (state)
        CLEAR: begin
          // Counter wraps to 0 naturally on the last address.
          clear_addr <= clear_addr + ADDR_WIDTH'(1);
          if (clear_addr == '1) begin
            state    <= RUN;
            ready_p1 <= 1'b1;
          end
        end
        RUN: begin
          if (ClearStart) begin
            state      <= CLEAR;
            clear_addr <= '0;
            ready_p1   <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          ready_p1 <= 1'b1;
        end
      endcase
    end
  end

  // ---- write port: the sweep has priority and blocks client writes ----
  always_ff @(posedge Clock) begin
    if (state == CLEAR) begin
      mem[clear_addr] <= '0;
    end else if (WriteEnable) begin
      mem[AddrIn] <= DataIn;
    end
  end

  // ---- read port, stage p1: registered data plus one-cycle valid ----
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) begin
        // The array read returns pre-edge contents. The write-first case
        // bypasses the incoming word so that it appears without an extra cycle.
        if (WRITE_FIRST && wr_acc && same_addr) rd_data_p1 <= DataIn;
        else                                    rd_data_p1 <= mem[AddrOut];
      end
    end
  end

  assign DataOut   = rd_data_p1;
  assign DataValid = vld_p1;
  assign Ready     = ready_p1;

endmodule

// File: tb/tb_sync_ram.sv
// -----------------------------------------------------------------------------
// tb_sync_ram
// This bench instantiates two 16-word RAMs. Instance a is read-first and runs
// a clear sweep after reset. Instance b is write-first and does no clear on
// reset. The expected read words are queued when a read is issued. A monitor
// per instance pops one word on each DataValid and compares it with DataOut.
// -----------------------------------------------------------------------------
module tb_sync_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rstn_a, we_a, re_a, cs_a, dv_a, rdy_a;
  logic [3:0] wa_a, ra_a;
  logic [7:0] din_a, dout_a;

  logic       rstn_b, we_b, re_b, cs_b, dv_b, rdy_b;
  logic [3:0] wa_b, ra_b;
  logic [7:0] din_b, dout_b;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)) dut_a (
    .Clock(clk), .ResetN(rstn_a), .WriteEnable(we_a), .AddrIn(wa_a), .DataIn(din_a),
    .ReadEnable(re_a), .AddrOut(ra_a), .DataOut(dout_a), .DataValid(dv_a),
    .ClearStart(cs_a), .Ready(rdy_a)
  );

  sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b0)) dut_b (
    .Clock(clk), .ResetN(rstn_b), .WriteEnable(we_b), .AddrIn(wa_b), .DataIn(din_b),
    .ReadEnable(re_b), .AddrOut(ra_b), .DataOut(dout_b), .DataValid(dv_b),
    .ClearStart(cs_b), .Ready(rdy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitors: each DataValid must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_valid: got valid data %0h expected no read", dout_a);
      end else begin
        check("a_rdata", dout_a, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (dv_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_valid: got valid data %0h expected no read", dout_b);
      end else begin
        check("b_rdata", dout_b, exp_b.pop_front());
      end
    end
  end

  // All drive tasks are entered just after a falling edge and leave at the next one.
  task automatic write_a(input logic [3:0] addr, input logic [7:0] data);
    we_a = 1'b1; wa_a = addr; din_a = data;
    @(negedge clk);
    we_a = 1'b0;
  endtask

  task automatic read_a(input logic [3:0] addr, input logic [7:0] exp);
    re_a = 1'b1; ra_a = addr;
    exp_a.push_back(exp);
    @(negedge clk);
    re_a = 1'b0;
  endtask

  task automatic read_b(input logic [3:0] addr, input logic [7:0] exp);
    re_b = 1'b1; ra_b = addr;
    exp_b.push_back(exp);
    @(negedge clk);
    re_b = 1'b0;
  endtask

  // Counts the sampled cycles with Ready low (bounded). With junk set, the task
  // holds write and read requests during the sweep and checks that they have no
  // effect.
  task automatic wait_ready_a(input string name, input int exp_n, input bit junk,
                              input logic [7:0] hold);
    int n = 0;
    if (junk) begin
      we_a = 1'b1; wa_a = 4'd9; din_a = 8'h77;
      re_a = 1'b1; ra_a = 4'd3;
    end
    while (rdy_a !== 1'b1 && n < 40) begin
      if (junk) begin
        check("a_sweep_dv", dv_a, 0);
        check("a_sweep_dout", dout_a, hold);
      end
      n++;
      @(negedge clk);
    end
    we_a = 1'b0; re_a = 1'b0;
    check(name, n, exp_n);
  endtask

  initial begin
    rstn_a = 1'b0; we_a = 1'b0; re_a = 1'b0; cs_a = 1'b0;
    wa_a = '0; ra_a = '0; din_a = '0;
    rstn_b = 1'b0; we_b = 1'b0; re_b = 1'b0; cs_b = 1'b0;
    wa_b = '0; ra_b = '0; din_b = '0;

    @(negedge clk);
    @(negedge clk);
    check("a_rst_ready", rdy_a, 0);
    check("a_rst_dv", dv_a, 0);
    check("a_rst_dout", dout_a, 0);
    check("b_rst_ready", rdy_b, 1);
    check("b_rst_dv", dv_b, 0);

    // Initial sweep, then preload 0xFF and reset again: the sweep must rezero.
    rstn_a = 1'b1;
    wait_ready_a("a_init_sweep_len", 16, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) write_a(4'(i), 8'hFF);
    rstn_a = 1'b0;
    @(negedge clk);
    rstn_a = 1'b1;
    wait_ready_a("a_reset_sweep_len", 16, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) read_a(4'(i), 8'h00);

    // Basic write then read, valid for exactly one cycle.
    write_a(4'd3, 8'hA5);
    read_a(4'd3, 8'hA5);
    check("a_rd_valid", dv_a, 1);
    check("a_rd_data", dout_a, 8'hA5);
    @(negedge clk);
    check("a_rd_valid_drop", dv_a, 0);
    check("a_rd_hold", dout_a, 8'hA5);

    // Read-first collision returns old data. The next read sees the new data.
    write_a(4'd7, 8'h11);
    we_a = 1'b1; wa_a = 4'd7; din_a = 8'h22;
    re_a = 1'b1; ra_a = 4'd7;
    exp_a.push_back(8'h11);
    @(negedge clk);
    we_a = 1'b0; re_a = 1'b0;
    read_a(4'd7, 8'h22);
    @(negedge clk);

    // ClearStart together with a write. Requests made during the sweep are ignored.
    we_a = 1'b1; wa_a = 4'd2; din_a = 8'h5A; cs_a = 1'b1;
    @(negedge clk);
    we_a = 1'b0; cs_a = 1'b0;
    check("a_cs_ready_fall", rdy_a, 0);
    wait_ready_a("a_cs_sweep_len", 16, 1'b1, 8'h22);
    for (int i = 0; i < 16; i++) read_a(4'(i), 8'h00);

    // Reset in the middle of a sweep while DataOut holds a non-zero word.
    write_a(4'd7, 8'h3C);
    read_a(4'd7, 8'h3C);
    @(negedge clk);
    check("a_pre_hold", dout_a, 8'h3C);
    cs_a = 1'b1;
    @(negedge clk);
    cs_a = 1'b0;
    repeat (9) @(posedge clk);
    #1 rstn_a = 1'b0;
    #1;
    check("a_midrst_ready", rdy_a, 0);
    check("a_midrst_dv", dv_a, 0);
    check("a_midrst_dout", dout_a, 0);
    @(negedge clk);
    rstn_a = 1'b1;
    wait_ready_a("a_midrst_sweep_len", 16, 1'b0, 8'h00);
    read_a(4'd7, 8'h00);

    // Instance b: Ready immediately after release, write-first collisions.
    @(negedge clk);
    rstn_b = 1'b1;
    check("b_ready_after_release", rdy_b, 1);
    we_b = 1'b1; wa_b = 4'd7; din_b = 8'h11;
    @(negedge clk);
    we_b = 1'b1; wa_b = 4'd7; din_b = 8'h22;
    re_b = 1'b1; ra_b = 4'd7;
    exp_b.push_back(8'h22);
    @(negedge clk);
    we_b = 1'b1; wa_b = 4'd4; din_b = 8'h44;
    read_b(4'd7, 8'h22);
    we_b = 1'b0;
    read_b(4'd4, 8'h44);
    @(negedge clk);

    repeat (3) @(negedge clk);
    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
